rand_range_buffer: RTL and testbench

RAND_RANGE_BUFFER -- requirements
Module: rand_range_buffer

---
 rtl/rand_range_pkg.sv | 39 +++
 rtl/rand_range_fifo.sv | 100 ++++++++++
 rtl/rand_range_buffer.sv | 176 +++++++++++++++++
 tb/tb_rand_range_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_range_pkg.sv
// ---------------------------------------------------------------------------
// rand_range_pkg
//
// Shared definitions for the rand_range_buffer block:
//   - state_t       : request FSM states (IDLE / REQ / WAIT)
//   - DEFAULT_DEPTH : default number of buffered results
//   - DEFAULT_W     : default random word width
//   - MASK_W        : widest word the mask helper supports
//   - smear_mask()  : copies the highest set bit of a word into every bit
//                     below it, giving the tightest all-ones mask that still
//                     covers the value.
// ---------------------------------------------------------------------------
package rand_range_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_W     = 32;

  // Words up to this width can be smeared; narrower words are zero-extended
  // on the way in and truncated on the way out.
  localparam int MASK_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // OR-shifting by 1, 2, 4, ... propagates the leading one all the way down
  // in log2(MASK_W) steps.
  function automatic logic [MASK_W-1:0] smear_mask(input logic [MASK_W-1:0] x);
    logic [MASK_W-1:0] m;
    m = x;
    for (int s = 1; s < MASK_W; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

endpackage : rand_range_pkg

// File: rtl/rand_range_fifo.sv
// ---------------------------------------------------------------------------
// rand_range_fifo
//
// Small circular buffer that holds accepted random results until the
// consumer takes them. The head entry is presented combinationally. When the
// buffer is empty, the head entry reads as zero.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   push_i       in   write push_data_i at the tail
//   pop_i        in   drop the head entry (ignored when empty)
//   flush_i      in   empty the buffer; wins over push/pop
//   push_data_i  in   W   data to write
//   pop_data_o   out  W   head entry, or 0 when empty
//   count_o      out  clog2(DEPTH+1)  occupancy
//   valid_o      out  buffer non-empty
// ---------------------------------------------------------------------------
module rand_range_fifo
  import rand_range_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = DEFAULT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               push_data_i,
  output logic [W-1:0]               pop_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       valid_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_ok;
  logic          pop_ok;

  // Flush suppresses both operations. A push on a full buffer is dropped as
  // a safeguard, although the request FSM never issues one.
  assign push_ok = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i  && !flush_i && (count_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents are never visible
  // while count is zero, so a reset would add cost and buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule : rand_range_fifo

// File: rtl/rand_range_buffer.sv
// ---------------------------------------------------------------------------
// rand_range_buffer
//
// Fetches raw random words from an upstream source, one request at a time.
// Each word is reduced to a value in [0, LIMIT) by masking and rejection,
// and accepted values are buffered for a downstream consumer.
//
// A word is masked down to the smallest all-ones mask that covers LIMIT-1.
// The masked value is kept only if it is below LIMIT, so the result stays
// uniform. LIMIT == 0 selects the full word range.
//
// Ports:
//   CLK             in   clock, rising edge
//   RESET           in   asynchronous active-high reset
//   LIMIT           in   W   exclusive upper bound (0 = full range)
//   FLUSH           in   drop buffered results and any in-flight response
//   SRC_REQ         out  one-cycle request pulse to the random source
//   SRC_RESP        in   W   random word from the source
//   SRC_RESP_VALID  in   SRC_RESP valid this cycle
//   OUT_DATA        out  W   head-of-buffer value (0 when empty)
//   OUT_VALID       out  buffer non-empty
//   OUT_READY       in   consumer pops when OUT_VALID && OUT_READY
//   COUNT           out  clog2(DEPTH+1)  buffer occupancy
//   REJECT_COUNT    out  16  saturating count of rejected samples
//                        (present only when RAND_RANGE_STATS_EN is defined)
//
// Build option:
//   RAND_RANGE_STATS_EN  adds the REJECT_COUNT port and its counter.
// ---------------------------------------------------------------------------
module rand_range_buffer
  import rand_range_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = DEFAULT_W
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [W-1:0]               LIMIT,
  input  logic                       FLUSH,
  output logic                       SRC_REQ,
  input  logic [W-1:0]               SRC_RESP,
  input  logic                       SRC_RESP_VALID,
  output logic [W-1:0]               OUT_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
`ifdef RAND_RANGE_STATS_EN
  ,
  output logic [15:0]                REJECT_COUNT
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_q, state_d;
  logic          discard_q, discard_d;
  logic          taken;
  logic [W-1:0]  limit_m1;
  logic [W-1:0]  mask;
  logic [W-1:0]  masked;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic          fifo_valid;

  // -------------------------------------------------------------------------
  // Response qualification and range reduction
  // -------------------------------------------------------------------------
  // A response counts only when a request is outstanding. In IDLE it is
  // ignored, which also covers late responses after a reset.
  assign taken = SRC_RESP_VALID && ((state_q == REQ) || (state_q == WAIT));

  // LIMIT == 0 wraps LIMIT-1 to all ones, so the mask becomes all ones.
  // LIMIT == 1 gives LIMIT-1 == 0, so the mask becomes zero.
  assign limit_m1 = LIMIT - W'(1);
  assign mask     = W'(smear_mask(MASK_W'(limit_m1)));
  assign masked   = SRC_RESP & mask;
  assign accept   = (LIMIT == '0) || (masked < LIMIT);

  // A response that arrives after a flush belongs to a request issued before
  // the flush, so it is dropped.
  assign push = taken && !discard_q && accept;
  assign pop  = OUT_READY && fifo_valid;

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;

    unique case (state_q)
      IDLE: begin
        // Only one request may be outstanding. A free slot is required, so a
        // push can never overflow the buffer.
        if (!FLUSH && (count < CW'(DEPTH))) state_d = REQ;
      end
      REQ: begin
        // A source with zero latency may answer in the request cycle itself.
        state_d = taken ? IDLE : WAIT;
      end
      WAIT: begin
        if (taken) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush with a request in flight marks the next response as stale. If
    // the response arrives in the flush cycle, the buffer flush already
    // drops it, so no mark is needed.
    if (taken) begin
      discard_d = 1'b0;
    end else if (FLUSH && (state_q != IDLE)) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  assign SRC_REQ = (state_q == REQ);

  // -------------------------------------------------------------------------
  // Result buffer
  // -------------------------------------------------------------------------
  rand_range_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RESET),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (FLUSH),
    .push_data_i (masked),
    .pop_data_o  (OUT_DATA),
    .count_o     (count),
    .valid_o     (fifo_valid)
  );

  assign COUNT     = count;
  assign OUT_VALID = fifo_valid;

  // -------------------------------------------------------------------------
  // Optional rejection statistics
  // -------------------------------------------------------------------------
`ifdef RAND_RANGE_STATS_EN
  logic [15:0] reject_q, reject_d;
  logic        rejected;

  // Stale responses dropped after a flush are not counted as rejections.
  assign rejected = taken && !discard_q && !accept;

  always_comb begin
    reject_d = reject_q;
    if (rejected && (reject_q != 16'hFFFF)) reject_d = reject_q + 16'd1;
  end

  // Only RESET clears the counter. FLUSH leaves it unchanged.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) reject_q <= '0;
    else       reject_q <= reject_d;
  end

  assign REJECT_COUNT = reject_q;
`endif

endmodule : rand_range_buffer

// File: tb/tb_rand_range_buffer.sv
// ---------------------------------------------------------------------------
// tb_rand_range_buffer
//
// Directed testbench for rand_range_buffer with the default build
// (DEPTH = 4, W = 32). Every expected value is worked out by hand from the
// range-reduction rule and the request FSM timing.
//
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// at that same point, so they reflect the state registered at that edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rand_range_buffer;

  logic        CLK;
  logic        RESET;
  logic [31:0] LIMIT;
  logic        FLUSH;
  logic        SRC_REQ;
  logic [31:0] SRC_RESP;
  logic        SRC_RESP_VALID;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [2:0]  COUNT;
`ifdef RAND_RANGE_STATS_EN
  logic [15:0] REJECT_COUNT;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  rand_range_buffer #(.DEPTH(4), .W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .LIMIT          (LIMIT),
    .FLUSH          (FLUSH),
    .SRC_REQ        (SRC_REQ),
    .SRC_RESP       (SRC_RESP),
    .SRC_RESP_VALID (SRC_RESP_VALID),
    .OUT_DATA       (OUT_DATA),
    .OUT_VALID      (OUT_VALID),
    .OUT_READY      (OUT_READY),
    .COUNT          (COUNT)
`ifdef RAND_RANGE_STATS_EN
    ,
    .REJECT_COUNT   (REJECT_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Absolute time limit, so a hung run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] lim);
    RESET          = 1'b1;
    LIMIT          = lim;
    FLUSH          = 1'b0;
    SRC_RESP       = '0;
    SRC_RESP_VALID = 1'b0;
    OUT_READY      = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Wait a bounded number of cycles for SRC_REQ. A timeout shows up as a
  // failed req_seen comparison.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (SRC_REQ !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, {31'd0, SRC_REQ}, 32'd1);
  endtask

  // Answer the next request after `lat` cycles. With lat = 0 the answer
  // comes in the REQ cycle; otherwise it comes in WAIT.
  task automatic xfer(input string tag, input logic [31:0] data, input int lat);
    wait_req(tag);
    repeat (lat) step();
    SRC_RESP       = data;
    SRC_RESP_VALID = 1'b1;
    step();
    SRC_RESP_VALID = 1'b0;
    SRC_RESP       = '0;
  endtask

  initial begin
    // ---------------- Reset state ----------------
    RESET = 1'b1; LIMIT = 32'd10; FLUSH = 1'b0;
    SRC_RESP = '0; SRC_RESP_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    check("rst_src_req",   {31'd0, SRC_REQ},   32'd0);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_out_data",  OUT_DATA,           32'd0);
    check("rst_count",     {29'd0, COUNT},     32'd0);
    step(); step();
    RESET = 1'b0;

    // ---------------- Accept in WAIT, LIMIT = 10 ----------------
    wait_req("t1");
    step();                                   // REQ -> WAIT
    check("t1_wait_no_req", {31'd0, SRC_REQ}, 32'd0);
    SRC_RESP = 32'h0000_0003; SRC_RESP_VALID = 1'b1;
    check("t1_no_bypass", {31'd0, OUT_VALID}, 32'd0);
    step();
    SRC_RESP_VALID = 1'b0;
    check("t1_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("t1_out_data",  OUT_DATA,           32'd3);
    check("t1_count",     {29'd0, COUNT},     32'd1);

    // ---------------- Reject 12 (mask 0xF), re-request after 2 cycles -------
    wait_req("t2");
    step();                                   // WAIT
    SRC_RESP = 32'h0000_000C; SRC_RESP_VALID = 1'b1;
    step();
    SRC_RESP_VALID = 1'b0;
    check("t2_count_kept", {29'd0, COUNT},   32'd1);
    check("t2_idle_req",   {31'd0, SRC_REQ}, 32'd0);
    step();
    check("t2_rereq",      {31'd0, SRC_REQ}, 32'd1);
`ifdef RAND_RANGE_STATS_EN
    check("t2_reject_cnt", {16'd0, REJECT_COUNT}, 32'd1);
`endif

    // ---------------- Zero-latency accept, boundary values ----------------
    SRC_RESP = 32'h0000_0007; SRC_RESP_VALID = 1'b1;   // still in REQ
    step();
    SRC_RESP_VALID = 1'b0;
    check("t3_zl_count", {29'd0, COUNT}, 32'd2);
    check("t3_zl_head",  OUT_DATA,       32'd3);
    xfer("t3a", 32'h0000_FF0A, 0);            // masked 10 == LIMIT -> reject
    check("t3_eq_limit_rej", {29'd0, COUNT}, 32'd2);
    xfer("t3b", 32'h1234_5679, 0);            // masked 9 -> accept
    check("t3_nine_acc", {29'd0, COUNT}, 32'd3);
    xfer("t3c", 32'h0000_0005, 2);            // accept 5 after extra WAIT cycle
    check("t3_full", {29'd0, COUNT}, 32'd4);

    // ---------------- Full buffer holds off requests ----------------
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_full_no_req", {31'd0, SRC_REQ}, 32'd0);
    end
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("t4_pop_count", {29'd0, COUNT},   32'd3);
    check("t4_pop_head",  OUT_DATA,         32'd7);
    check("t4_pop_noreq", {31'd0, SRC_REQ}, 32'd0);
    step();
    check("t4_req_after_pop", {31'd0, SRC_REQ}, 32'd1);
    // Simultaneous push and pop
    step();                                   // WAIT
    SRC_RESP = 32'h0000_0002; SRC_RESP_VALID = 1'b1; OUT_READY = 1'b1;
    step();
    SRC_RESP_VALID = 1'b0; OUT_READY = 1'b0;
    check("t4_pushpop_count", {29'd0, COUNT}, 32'd3);
    check("t4_pushpop_head",  OUT_DATA,       32'd9);

    // ---------------- Flush while in WAIT ----------------
    wait_req("t5");
    step();                                   // WAIT
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    check("t5_flush_count", {29'd0, COUNT},     32'd0);
    check("t5_flush_valid", {31'd0, OUT_VALID}, 32'd0);
    check("t5_flush_data",  OUT_DATA,           32'd0);
    SRC_RESP = 32'h0000_0005; SRC_RESP_VALID = 1'b1;
    step();
    SRC_RESP_VALID = 1'b0;
    check("t5_discard_count", {29'd0, COUNT},     32'd0);
    check("t5_discard_valid", {31'd0, OUT_VALID}, 32'd0);
    xfer("t5b", 32'h0000_0004, 0);
    check("t5_after_count", {29'd0, COUNT}, 32'd1);
    check("t5_after_data",  OUT_DATA,       32'd4);
    // Flush wins over a simultaneous push
    wait_req("t5c");
    SRC_RESP = 32'h0000_0006; SRC_RESP_VALID = 1'b1; FLUSH = 1'b1;
    step();
    SRC_RESP_VALID = 1'b0; FLUSH = 1'b0;
    check("t5_flush_prio", {29'd0, COUNT}, 32'd0);
    xfer("t5d", 32'h0000_0008, 0);
    check("t5_nostale_data", OUT_DATA, 32'd8);

    // ---------------- LIMIT = 0 (full range) and LIMIT = 1 ----------------
    apply_reset(32'd0);
    xfer("t6a", 32'hDEAD_BEEF, 0);
    check("t6_full_range", OUT_DATA, 32'hDEAD_BEEF);
    apply_reset(32'd1);
    xfer("t6b", 32'hFFFF_FFFF, 1);
    check("t6_limit1_data",  OUT_DATA,           32'd0);
    check("t6_limit1_valid", {31'd0, OUT_VALID}, 32'd1);

    // ---------------- Pointer wrap with continuous pop, LIMIT = 100 -----------
    apply_reset(32'd100);
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xfer("t7", 32'h0000_0100 | (i * 17), 0); // mask 0x7F strips bit 8
      check("t7_wrap_data",  OUT_DATA,       i * 17);
      check("t7_wrap_count", {29'd0, COUNT}, 32'd1);
    end
    step();
    check("t7_pop_empty", {29'd0, COUNT}, 32'd0);
    OUT_READY = 1'b0;

    // ---------------- Reset mid-WAIT with COUNT = 2 ----------------
    apply_reset(32'd10);
    xfer("t8a", 32'h0000_0001, 0);
    xfer("t8b", 32'h0000_0002, 0);
    check("t8_pre_count", {29'd0, COUNT}, 32'd2);
    wait_req("t8c");
    step();                                   // WAIT
    #2 RESET = 1'b1;
    #1;
    check("t8_async_src_req",   {31'd0, SRC_REQ},   32'd0);
    check("t8_async_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("t8_async_out_data",  OUT_DATA,           32'd0);
    check("t8_async_count",     {29'd0, COUNT},     32'd0);
    SRC_RESP = 32'h0000_0003; SRC_RESP_VALID = 1'b1;
    step();
    RESET = 1'b0;
    step();                                   // late response seen in IDLE
    SRC_RESP_VALID = 1'b0;
    check("t8_late_count", {29'd0, COUNT},     32'd0);
    check("t8_late_valid", {31'd0, OUT_VALID}, 32'd0);
    check("t8_late_req",   {31'd0, SRC_REQ},   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_rand_range_buffer
